// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the operand-forwarding / hazard unit.
package fwd_hazard_unit_pkg;

    // Forward-valid encodings
    localparam logic FORWARD_ENABLE  = 1'b1;
    localparam logic FORWARD_DISABLE = 1'b0;

    // Register address codes (GPRs occupy 0..7)
    localparam logic [3:0] REG_SP    = 4'h8;
    localparam logic [3:0] REG_IH    = 4'h9;
    localparam logic [3:0] REG_T     = 4'hA;
    localparam logic [3:0] REG_RA    = 4'hB;
    localparam logic [3:0] ADDR_NONE = 4'hF;   // "no register", never matches

    // Value driven on a data bus that carries nothing
    localparam logic [15:0] EMPTY_DATA = 16'h0000;

    // Stall watchdog states
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline <-> forwarding unit bundle: decode sources, in-flight stages,
// retire port, and the forwarding / stall results.
interface fwd_hazard_unit_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int CNT_W   = 32
) ();
    logic                        flush;
    logic [NUM_SRC*ADDR_W-1:0]   src_addr;
    logic [NUM_SRC-1:0]          src_used;
    logic [NUM_STG-1:0]          stg_wb_en;
    logic [NUM_STG*ADDR_W-1:0]   stg_wb_addr;
    logic [NUM_STG*DATA_W-1:0]   stg_wb_data;
    logic [NUM_STG-1:0]          stg_data_rdy;
    logic                        ret_wb_en;
    logic [ADDR_W-1:0]           ret_wb_addr;
    logic [DATA_W-1:0]           ret_wb_data;
    logic [NUM_SRC-1:0]          fwd_en;
    logic [NUM_SRC*DATA_W-1:0]   fwd_data;
    logic                        stall;
    logic                        err_timeout;
    logic [CNT_W-1:0]            stall_cycles;

    // Pipeline side
    modport master (
        output flush, src_addr, src_used, stg_wb_en, stg_wb_addr, stg_wb_data,
               stg_data_rdy, ret_wb_en, ret_wb_addr, ret_wb_data,
        input  fwd_en, fwd_data, stall, err_timeout, stall_cycles
    );

    // Forwarding unit side
    modport slave (
        input  flush, src_addr, src_used, stg_wb_en, stg_wb_addr, stg_wb_data,
               stg_data_rdy, ret_wb_en, ret_wb_addr, ret_wb_data,
        output fwd_en, fwd_data, stall, err_timeout, stall_cycles
    );
endinterface

// File: rtl/fwd_hazard_unit_src_select.sv
// Single-source priority matcher: youngest matching stage wins, a not-ready
// winner is a hazard, and the retire history is only a fallback.
module fwd_src_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int               DATA_W    = 16,
    parameter int               ADDR_W    = 4,
    parameter int               NUM_STG   = 2,
    parameter logic [ADDR_W-1:0] NONE_ADDR = ADDR_NONE
) (
    input  logic [ADDR_W-1:0]         src_addr_i,
    input  logic                      src_used_i,
    input  logic [NUM_STG-1:0]        stg_wb_en_i,
    input  logic [NUM_STG*ADDR_W-1:0] stg_wb_addr_i,
    input  logic [NUM_STG*DATA_W-1:0] stg_wb_data_i,
    input  logic [NUM_STG-1:0]        stg_data_rdy_i,
    input  logic                      hist_vld_i,
    input  logic [ADDR_W-1:0]         hist_addr_i,
    input  logic [DATA_W-1:0]         hist_data_i,
    output logic                      fwd_en_o,
    output logic [DATA_W-1:0]         fwd_data_o,
    output logic                      hazard_o
);
    logic               src_valid;
    logic [NUM_STG-1:0] match;
    logic               stg_hit;

    assign src_valid = src_used_i && (src_addr_i != NONE_ADDR);

    for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_match
        assign match[gi] = src_valid && stg_wb_en_i[gi] &&
                           (stg_wb_addr_i[gi*ADDR_W +: ADDR_W] == src_addr_i);
    end

    assign stg_hit = |match;

    // Scan oldest to youngest so the youngest match is the last one written
    always_comb begin
        fwd_en_o   = FORWARD_DISABLE;
        fwd_data_o = DATA_W'(EMPTY_DATA);
        hazard_o   = 1'b0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (match[k]) begin
                if (stg_data_rdy_i[k]) begin
                    fwd_en_o   = FORWARD_ENABLE;
                    fwd_data_o = stg_wb_data_i[k*DATA_W +: DATA_W];
                    hazard_o   = 1'b0;
                end else begin
                    fwd_en_o   = FORWARD_DISABLE;
                    fwd_data_o = DATA_W'(EMPTY_DATA);
                    hazard_o   = 1'b1;
                end
            end
        end
        if (!stg_hit && src_valid && hist_vld_i && (hist_addr_i == src_addr_i)) begin
            fwd_en_o   = FORWARD_ENABLE;
            fwd_data_o = hist_data_i;
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding / hazard unit top: per-source matchers, one-entry retire
// history, stall watchdog FSM and saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 4,
    parameter int                NUM_SRC   = 2,
    parameter int                NUM_STG   = 2,
    parameter logic [ADDR_W-1:0] NONE_ADDR = ADDR_NONE,
    parameter int                MAX_STALL = 8,
    parameter int                CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_unit_if.slave   bus
);
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [NUM_SRC-1:0]        en_raw;
    logic [NUM_SRC*DATA_W-1:0] data_raw;
    logic [NUM_SRC-1:0]        hazard;
    logic                      stall_w;

    logic                      hist_vld_q, hist_vld_d;
    logic [ADDR_W-1:0]         hist_addr_q;
    logic [DATA_W-1:0]         hist_data_q;
    stall_state_e              state_q, state_d;
    logic [RUN_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [CNT_W-1:0]          stall_cycles_q, stall_cycles_d;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_src_select #(
            .DATA_W    (DATA_W),
            .ADDR_W    (ADDR_W),
            .NUM_STG   (NUM_STG),
            .NONE_ADDR (NONE_ADDR)
        ) u_sel (
            .src_addr_i     (bus.src_addr[gi*ADDR_W +: ADDR_W]),
            .src_used_i     (bus.src_used[gi]),
            .stg_wb_en_i    (bus.stg_wb_en),
            .stg_wb_addr_i  (bus.stg_wb_addr),
            .stg_wb_data_i  (bus.stg_wb_data),
            .stg_data_rdy_i (bus.stg_data_rdy),
            .hist_vld_i     (hist_vld_q),
            .hist_addr_i    (hist_addr_q),
            .hist_data_i    (hist_data_q),
            .fwd_en_o       (en_raw[gi]),
            .fwd_data_o     (data_raw[gi*DATA_W +: DATA_W]),
            .hazard_o       (hazard[gi])
        );
    end

    // Several hazarding sources collapse into one stall
    assign stall_w = |hazard;

    // Combinational outputs are forced quiet while reset is asserted
    assign bus.fwd_en       = rst_n ? en_raw   : '0;
    assign bus.fwd_data     = rst_n ? data_raw : '0;
    assign bus.stall        = rst_n & stall_w;
    assign bus.err_timeout  = err_q;
    assign bus.stall_cycles = stall_cycles_q;

    // Next-state: history validity, watchdog FSM, sticky error, stall counter
    always_comb begin
        hist_vld_d     = bus.ret_wb_en && (bus.ret_wb_addr != NONE_ADDR);
        state_d        = state_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            ST_RUN: begin
                if (stall_w) begin
                    state_d = ST_STALL;
                    cnt_d   = RUN_W'(1);
                end
            end
            ST_STALL: begin
                if (stall_w) begin
                    if (cnt_q < RUN_MAX) cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (stall_w && (cnt_d == RUN_MAX)) err_d = 1'b1;
        if (stall_w && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
        // Flush restarts the run but keeps the sticky error and the statistics
        if (bus.flush) begin
            hist_vld_d     = 1'b0;
            state_d        = ST_RUN;
            cnt_d          = '0;
            err_d          = err_q;
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers; history address/data load every cycle, validity gates use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld_q     <= 1'b0;
            hist_addr_q    <= '0;
            hist_data_q    <= '0;
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            hist_vld_q     <= hist_vld_d;
            hist_addr_q    <= bus.ret_wb_addr;
            hist_data_q    <= bus.ret_wb_data;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule
